div_ctrl: RTL and testbench

Sequencer for the iterative 32-bit divider used by `DIVW`, `MODW`, `DIVWU` and `MODWU`. It sits beside the ex stage. It accepts one divide request at a time, runs a radix-2 restoring shift-subtract loop for 32 cycles, and holds ex with `pause_o` until the result is ready. It applies LoongArch sign rules, resolves divide-by-zero without iterating, and aborts on pipeline flush.

---
 rtl/div_ctrl.sv | 150 +++++++++++++++
 tb/tb_div_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// div_ctrl: iterative 32-bit divide sequencer for DIVW/MODW/DIVWU/MODWU.
// Radix-2 restoring shift-subtract, one quotient bit per cycle, with
// LoongArch sign rules, a short-cut for divide-by-zero, and flush abort.
// Optional build macro: DIV_SMALL_SKIP_EN (finish in one cycle when
// |dividend| < |divisor|; the result is bit-identical either way).
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start_i; operands latched on the accepting edge
// CALC  | 32 shift-subtract iterations, pause_o held high
// DONE  | ready_o pulse, result_o valid; always returns to IDLE
module div_ctrl #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              signed_i,
   input  logic              mod_i,
   input  logic [DATA_W-1:0] dividend_i,
   input  logic [DATA_W-1:0] divisor_i,
   input  logic              cancel_i,
   output logic              pause_o,
   output logic              ready_o,
   output logic [DATA_W-1:0] result_o,
   output logic              busy_o
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [2*DATA_W-1:0] rq;
   logic [DATA_W-1:0]   div_mag;
   logic                mod_r;
   logic                neg_q;
   logic                neg_r;

   logic [DATA_W-1:0]   dvd_mag;
   logic [DATA_W-1:0]   dvs_mag;
   logic [DATA_W:0]     trial;
   logic [2*DATA_W-1:0] rq_nxt;
   logic [DATA_W-1:0]   fin_q;
   logic [DATA_W-1:0]   fin_r;
   logic [DATA_W-1:0]   res_calc;

   // Operand magnitudes: two's-complement absolute value only in signed mode.
   // 0x80000000 maps to itself, which is the correct unsigned magnitude.
   always_comb begin
      dvd_mag = (signed_i && dividend_i[DATA_W-1]) ? -dividend_i : dividend_i;
      dvs_mag = (signed_i && divisor_i[DATA_W-1])  ? -divisor_i  : divisor_i;
   end

   // One restoring step: the trial uses the shifted-up remainder (33 bits,
   // so the bit leaving the top of rq is not lost) minus the divisor.
   always_comb begin
      trial = rq[2*DATA_W-1:DATA_W-1] - {1'b0, div_mag};
      if (trial[DATA_W])
         rq_nxt = {rq[2*DATA_W-2:0], 1'b0};
      else
         rq_nxt = {trial[DATA_W-1:0], rq[DATA_W-2:0], 1'b1};
      fin_q = rq_nxt[DATA_W-1:0];
      fin_r = rq_nxt[2*DATA_W-1:DATA_W];
      if (mod_r)
         res_calc = neg_r ? -fin_r : fin_r;
      else
         res_calc = neg_q ? -fin_q : fin_q;
   end

   // Stall ex from the accepting cycle through the last iteration; low in DONE.
   assign pause_o = rst && ((state == IDLE && start_i && !cancel_i) || state == CALC);
   assign busy_o  = (state != IDLE);

   // Sequencer: operand capture, iteration, sign fixup and result register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         rq       <= '0;
         div_mag  <= '0;
         mod_r    <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         ready_o  <= 1'b0;
         result_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               ready_o <= 1'b0;
               if (start_i && !cancel_i) begin
                  mod_r   <= mod_i;
                  neg_q   <= signed_i && (dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1]);
                  neg_r   <= signed_i && dividend_i[DATA_W-1];
                  div_mag <= dvs_mag;
                  rq      <= {{DATA_W{1'b0}}, dvd_mag};
                  cnt     <= '0;
                  if (divisor_i == '0) begin
                     result_o <= mod_i ? dividend_i : '1;
                     ready_o  <= 1'b1;
                     state    <= DONE;
                  end
`ifdef DIV_SMALL_SKIP_EN
                  else if (dvd_mag < dvs_mag) begin
                     // Quotient is 0 and the remainder is the dividend itself,
                     // which already carries the dividend's sign.
                     result_o <= mod_i ? dividend_i : '0;
                     ready_o  <= 1'b1;
                     state    <= DONE;
                  end
`endif
                  else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               if (cancel_i) begin
                  state <= IDLE;
               end else begin
                  rq <= rq_nxt;
                  if (cnt == CNT_LAST) begin
                     result_o <= res_calc;
                     ready_o  <= 1'b1;
                     state    <= DONE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            DONE: begin
               // A start_i still high here belongs to the finishing instruction.
               ready_o <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               ready_o <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_ctrl.sv
// Testbench for div_ctrl: table of directed divides, hand-written cancel and
// reset sequences, then random divides against an arithmetic reference model.
module tb_div_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic        signed_i;
   logic        mod_i;
   logic [31:0] dividend_i;
   logic [31:0] divisor_i;
   logic        cancel_i;
   logic        pause_o;
   logic        ready_o;
   logic [31:0] result_o;
   logic        busy_o;

   int n_vec = 0;
   int n_err = 0;

   div_ctrl #(.DATA_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .signed_i   (signed_i),
      .mod_i      (mod_i),
      .dividend_i (dividend_i),
      .divisor_i  (divisor_i),
      .cancel_i   (cancel_i),
      .pause_o    (pause_o),
      .ready_o    (ready_o),
      .result_o   (result_o),
      .busy_o     (busy_o)
   );

   always #5 clk = ~clk;

`ifdef DIV_SMALL_SKIP_EN
   localparam int SMALL_LAT = 1;
`else
   localparam int SMALL_LAT = 33;
`endif

   typedef struct {
      logic        sgn;
      logic        md;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic. Truncating division in SV already
   // gives quotient toward zero and a remainder with the dividend's sign.
   function automatic logic [31:0] ref_div(input logic s, input logic m,
                                           input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) return m ? a : 32'hFFFF_FFFF;
      if (s) begin
         sa = {{32{a[31]}}, a};
         sb = {{32{b[31]}}, b};
      end else begin
         sa = {32'd0, a};
         sb = {32'd0, b};
      end
      q = sa / sb;
      r = sa % sb;
      return m ? r[31:0] : q[31:0];
   endfunction

   function automatic int ref_lat(input logic s, input logic [31:0] a, input logic [31:0] b);
      longint ma, mb;
      if (b == 32'd0) return 1;
      ma = (s && a[31]) ? -longint'({{32{a[31]}}, a}) : longint'({32'd0, a});
      mb = (s && b[31]) ? -longint'({{32{b[31]}}, b}) : longint'({32'd0, b});
      if (ma < mb) return SMALL_LAT;
      return 33;
   endfunction

   // Called at posedge+1 with the DUT idle. Holds start through DONE,
   // then drops it and confirms the DUT is back in IDLE.
   task automatic run_op(input string nm, input logic s, input logic m,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat);
      int k;
      int pc;
      bit got;
      signed_i   = s;
      mod_i      = m;
      dividend_i = a;
      divisor_i  = b;
      start_i    = 1'b1;
      #1;
      pc  = pause_o ? 1 : 0;
      got = 1'b0;
      k   = 0;
      while (!got && k < 100) begin
         @(posedge clk);
         #1;
         k++;
         if (ready_o) got = 1'b1;
         else if (pause_o) pc++;
      end
      chk({nm, " ready seen"}, 32'(got), 32'd1);
      chk({nm, " latency"}, 32'(k), 32'(lat));
      chk({nm, " pause cycles"}, 32'(pc), 32'(lat));
      chk({nm, " pause in ready cycle"}, 32'(pause_o), 32'd0);
      chk({nm, " result"}, result_o, exp);
      @(posedge clk);
      #1;
      start_i = 1'b0;
      chk({nm, " ready one cycle"}, 32'(ready_o), 32'd0);
      chk({nm, " idle after done"}, 32'(busy_o), 32'd0);
      chk({nm, " result held"}, result_o, exp);
   endtask

   vec_t vt[$];

   initial begin
      logic [31:0] ra, rb, last;
      logic        rs, rm;

      vt.push_back('{1'b1, 1'b0, 32'd7,          32'd2,          32'd3,          33});
      vt.push_back('{1'b1, 1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33});
      vt.push_back('{1'b1, 1'b0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33});
      vt.push_back('{1'b0, 1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  33});
      vt.push_back('{1'b0, 1'b0, 32'hFFFF_FFFF,  32'h10,         32'h0FFF_FFFF,  33});
      vt.push_back('{1'b0, 1'b1, 32'hFFFF_FFFF,  32'h10,         32'h0000_000F,  33});
      vt.push_back('{1'b1, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33});
      vt.push_back('{1'b1, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000,  33});
      vt.push_back('{1'b0, 1'b0, 32'h1234,       32'd0,          32'hFFFF_FFFF,  1});
      vt.push_back('{1'b0, 1'b1, 32'h1234,       32'd0,          32'h1234,       1});
      vt.push_back('{1'b1, 1'b0, 32'hFFFF_FFF0,  32'd0,          32'hFFFF_FFFF,  1});
      vt.push_back('{1'b1, 1'b1, 32'hFFFF_FFF0,  32'd0,          32'hFFFF_FFF0,  1});
      vt.push_back('{1'b1, 1'b0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33});
      vt.push_back('{1'b1, 1'b1, 32'd7,          32'hFFFF_FFFE,  32'd1,          33});
      vt.push_back('{1'b1, 1'b0, 32'd3,          32'd5,          32'd0,          SMALL_LAT});
      vt.push_back('{1'b1, 1'b1, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFFD,  SMALL_LAT});

      rst = 1'b0; start_i = 1'b0; signed_i = 1'b0; mod_i = 1'b0;
      dividend_i = '0; divisor_i = '0; cancel_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset pause", 32'(pause_o), 32'd0);
      chk("reset ready", 32'(ready_o), 32'd0);
      chk("reset busy", 32'(busy_o), 32'd0);
      chk("reset result", result_o, 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      foreach (vt[i])
         run_op($sformatf("vec%0d", i), vt[i].sgn, vt[i].md, vt[i].a, vt[i].b,
                vt[i].exp, vt[i].lat);

      // Cancel in the 10th CALC cycle: nothing completes, result untouched.
      run_op("pre-cancel", 1'b1, 1'b0, 32'd7, 32'd2, 32'd3, 33);
      last = 32'd3;
      signed_i = 1'b0; mod_i = 1'b0; dividend_i = 32'd100; divisor_i = 32'd3;
      start_i = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("busy before cancel", 32'(busy_o), 32'd1);
      cancel_i = 1'b1;
      start_i  = 1'b0;
      @(posedge clk);
      #1;
      chk("cancel busy", 32'(busy_o), 32'd0);
      chk("cancel ready", 32'(ready_o), 32'd0);
      chk("cancel result", result_o, last);
      cancel_i = 1'b0;
      begin
         int rc = 0;
         repeat (3) begin
            @(posedge clk);
            #1;
            if (ready_o) rc++;
         end
         chk("no ready after cancel", 32'(rc), 32'd0);
      end
      run_op("after cancel", 1'b0, 1'b0, 32'd100, 32'd3, 32'd33, 33);

      // Reset in the 20th CALC cycle.
      signed_i = 1'b0; mod_i = 1'b0; dividend_i = 32'hFFFF_FFFF; divisor_i = 32'd7;
      start_i = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      rst = 1'b0;
      start_i = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst pause", 32'(pause_o), 32'd0);
      chk("midrst ready", 32'(ready_o), 32'd0);
      chk("midrst busy", 32'(busy_o), 32'd0);
      chk("midrst result", result_o, 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Reset wins over a simultaneous start.
      start_i = 1'b1; rst = 1'b0; divisor_i = 32'd3;
      @(posedge clk);
      #1;
      chk("rst vs start busy", 32'(busy_o), 32'd0);
      start_i = 1'b0; rst = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 40; i++) begin
         rs = 1'($urandom);
         rm = 1'($urandom);
         case ($urandom_range(0, 3))
            0: ra = $urandom_range(0, 20);
            1: ra = 32'h8000_0000;
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 4))
            0: rb = 32'd0;
            1: rb = $urandom_range(1, 15);
            2: rb = -($urandom_range(1, 15));
            3: rb = 32'hFFFF_FFFF;
            default: rb = $urandom;
         endcase
         run_op($sformatf("rand%0d", i), rs, rm, ra, rb, ref_div(rs, rm, ra, rb),
                ref_lat(rs, ra, rb));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
